// File: rtl/jpeg_pkg.sv
// Shared widths, zigzag/quantization tables and FSM state type for the
// JPEG DCT quantize-and-zigzag stage.
package jpeg_pkg;

    localparam int N       = 8;
    localparam int IN_W    = 4*N - 12;
    localparam int OUT_W   = 12;
    localparam int RECIP_W = 17;

    typedef enum logic {FILL, DRAIN} state_t;

    // Scan position k -> raster index (row*8 + col)
    localparam logic [5:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    localparam logic [7:0] QLUM [64] = '{
        8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
        8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
        8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
        8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
        8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
        8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
        8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
        8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
    };

    // round(65536 / QLUM[i])
    localparam logic [RECIP_W-1:0] RECIP_LUM [64] = '{
        17'd4096, 17'd5958, 17'd6554, 17'd4096, 17'd2731, 17'd1638, 17'd1285, 17'd1074,
        17'd5461, 17'd5461, 17'd4681, 17'd3449, 17'd2521, 17'd1130, 17'd1092, 17'd1192,
        17'd4681, 17'd5041, 17'd4096, 17'd2731, 17'd1638, 17'd1150, 17'd950,  17'd1170,
        17'd4681, 17'd3855, 17'd2979, 17'd2260, 17'd1285, 17'd753,  17'd819,  17'd1057,
        17'd3641, 17'd2979, 17'd1771, 17'd1170, 17'd964,  17'd601,  17'd636,  17'd851,
        17'd2731, 17'd1872, 17'd1192, 17'd1024, 17'd809,  17'd630,  17'd580,  17'd712,
        17'd1337, 17'd1024, 17'd840,  17'd753,  17'd636,  17'd542,  17'd546,  17'd649,
        17'd910,  17'd712,  17'd690,  17'd669,  17'd585,  17'd655,  17'd636,  17'd662
    };

endpackage

// File: rtl/quant_round_sat.sv
// Combinational quantizer: |x| * reciprocal, round half away from zero,
// restore sign and saturate to the symmetric output range.
module quant_round_sat
    import jpeg_pkg::*;
#(
    parameter int XW = IN_W,
    parameter int QW = OUT_W,
    parameter int RW = RECIP_W
) (
    input  logic signed [XW-1:0] x,
    input  logic        [RW-1:0] recip,
    output logic signed [QW-1:0] q
);

    localparam int PW = XW + RW;
    localparam int SW = PW - 16;
    localparam logic [SW-1:0] QMAX = SW'(2**(QW-1) - 1);

    logic          neg;
    logic [XW-1:0] mag;
    logic [PW-1:0] prod;
    logic [SW-1:0] scaled;
    logic [QW-2:0] mag_sat;

    // Magnitude is unsigned so the most-negative input maps to 2^(XW-1) cleanly
    always_comb begin
        neg = x[XW-1];
        mag = $unsigned(x);
        if (neg) mag = ~mag + 1'b1;
        prod    = PW'(mag) * PW'(recip);
        scaled  = SW'((prod + PW'(32768)) >> 16);
        mag_sat = (scaled > QMAX) ? QMAX[QW-2:0] : scaled[QW-2:0];
        q       = neg ? -$signed({1'b0, mag_sat}) : $signed({1'b0, mag_sat});
    end

endmodule

// File: rtl/dct_quant_zigzag.sv
// Buffers an 8x8 DCT block column by column, then streams the quantized
// coefficients out in zigzag order with a valid/ready handshake.
module dct_quant_zigzag
    import jpeg_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  Y0,
    input  logic signed [IN_W-1:0]  Y1,
    input  logic signed [IN_W-1:0]  Y2,
    input  logic signed [IN_W-1:0]  Y3,
    input  logic signed [IN_W-1:0]  Y4,
    input  logic signed [IN_W-1:0]  Y5,
    input  logic signed [IN_W-1:0]  Y6,
    input  logic signed [IN_W-1:0]  Y7,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic [5:0]              out_index,
    output logic                    out_last
);

    logic signed [IN_W-1:0]  coef_buf [64];
    logic signed [IN_W-1:0]  col_in [8];
    state_t                  state;
    logic [2:0]              col;
    logic [5:0]              k;
    logic [5:0]              next_k;
    logic                    accept;
    logic                    advance;
    logic [5:0]              src_idx;
    logic signed [IN_W-1:0]  src_x;
    logic signed [OUT_W-1:0] q;

    assign in_ready = (state == FILL);
    assign accept   = in_valid && in_ready;
    assign advance  = out_valid && out_ready;
    assign next_k   = k + 6'd1;

    always_comb begin
        col_in[0] = Y0;
        col_in[1] = Y1;
        col_in[2] = Y2;
        col_in[3] = Y3;
        col_in[4] = Y4;
        col_in[5] = Y5;
        col_in[6] = Y6;
        col_in[7] = Y7;
    end

    // The column arriving with the last FILL beat is not yet in the buffer,
    // so any raster entry in column 7 is taken straight from the inputs.
    always_comb begin
        src_idx = (state == FILL) ? ZIGZAG[0] : ZIGZAG[next_k];
        if (state == FILL && col == 3'd7 && src_idx[2:0] == 3'd7)
            src_x = col_in[src_idx[5:3]];
        else
            src_x = coef_buf[src_idx];
    end

    quant_round_sat u_quant (
        .x     (src_x),
        .recip (RECIP_LUM[src_idx]),
        .q     (q)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 8; r++)
                coef_buf[{3'(r), col}] <= col_in[r];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FILL;
            col       <= 3'd0;
            k         <= 6'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= 6'd0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        col <= col + 3'd1;
                        if (col == 3'd7) begin
                            state     <= DRAIN;
                            k         <= 6'd0;
                            out_valid <= 1'b1;
                            out_data  <= q;
                            out_index <= 6'd0;
                            out_last  <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (advance) begin
                        if (k == 6'd63) begin
                            state     <= FILL;
                            k         <= 6'd0;
                            out_valid <= 1'b0;
                            out_index <= 6'd0;
                            out_last  <= 1'b0;
                        end else begin
                            k         <= next_k;
                            out_data  <= q;
                            out_index <= next_k;
                            out_last  <= (next_k == 6'd63);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
